alu_shift_sequencer: RTL and testbench

//  Multi-cycle shift/rotate engine that drives the single-bit shift ops of the

---
 rtl/alu_pkg.sv | 33 +++
 rtl/shift_step_counter.sv | 27 ++
 rtl/alu_shift_sequencer.sv | 115 +++++++++++
 tb/tb_alu_shift_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: operand width, op encodings and the shift-sequencer state encoding.
// The ALU control decoder uses the same op values.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_AMT_W = 5;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

    // True for the five single-bit shift/rotate ops the sequencer may iterate.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_ASR) || (op == OP_LSL) || (op == OP_LSR) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Loadable down-counter for the remaining ALU steps; last is high while one step remains.
module shift_step_counter #(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [AMT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [AMT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign last = (count_reg == {{(AMT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift/rotate engine: loops the external ALU's single-bit shift result back
// into its A input once per clock until the requested amount has been applied.
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int AMT_W = ALU_AMT_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    output logic             Ready,
    input  logic [3:0]       ShiftOp,
    input  logic [WIDTH-1:0] Data,
    input  logic [AMT_W-1:0] Amount,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluZero,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             ResultZero,
    output logic             Err
);

    seq_state_t       state_reg, state_next;
    logic [WIDTH-1:0] acc_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             result_zero_reg;
    logic             err_reg;

    logic accept;
    logic legal_op;
    logic amount_zero;
    logic step_last;

    assign accept      = Start && (state_reg == ST_IDLE);
    assign legal_op    = is_shift_op(ShiftOp);
    assign amount_zero = (Amount == '0);

    shift_step_counter #(
        .AMT_W (AMT_W)
    ) u_step_counter (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (accept),
        .load_val (Amount),
        .dec      (state_reg == ST_RUN),
        .last     (step_last)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (legal_op && !amount_zero) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (step_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Zero-step and illegal requests complete straight from the sampled Data,
    // so Result never waits on an accumulator load.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_reg         <= '0;
            op_reg          <= OP_ADD;
            result_reg      <= '0;
            result_zero_reg <= 1'b1;
            err_reg         <= 1'b0;
        end else if (accept) begin
            acc_reg <= Data;
            op_reg  <= ShiftOp;
            err_reg <= !legal_op;
            if (!legal_op || amount_zero) begin
                result_reg      <= Data;
                result_zero_reg <= (Data == '0);
            end
        end else if (state_reg == ST_RUN) begin
            acc_reg <= AluOut;
            if (step_last) begin
                result_reg      <= AluOut;
                result_zero_reg <= AluZero;
            end
        end
    end

    assign Ready      = (state_reg == ST_IDLE);
    assign Done       = (state_reg == ST_DONE);
    assign AluA       = acc_reg;
    assign AluB       = '0;
    assign AluOp      = (state_reg == ST_RUN) ? op_reg : OP_ADD;
    assign Result     = result_reg;
    assign ResultZero = result_zero_reg;
    assign Err        = err_reg;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench: sequencer wired to a behavioural single-bit-shift ALU, expectations hand-computed.
module tb_alu_shift_sequencer;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Ready;
    logic [3:0]  ShiftOp;
    logic [31:0] Data;
    logic [4:0]  Amount;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [3:0]  AluOp;
    logic [31:0] AluOut;
    logic        AluZero;
    logic        Done;
    logic [31:0] Result;
    logic        ResultZero;
    logic        Err;

    int total = 0;
    int bad   = 0;

    alu_shift_sequencer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Ready      (Ready),
        .ShiftOp    (ShiftOp),
        .Data       (Data),
        .Amount     (Amount),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluOp      (AluOp),
        .AluOut     (AluOut),
        .AluZero    (AluZero),
        .Done       (Done),
        .Result     (Result),
        .ResultZero (ResultZero),
        .Err        (Err)
    );

    // Behavioural ALU (responder side)
    always_comb begin
        case (AluOp)
            4'b1000: AluOut = {AluA[31], AluA[31:1]};
            4'b1010: AluOut = {1'b0, AluA[31:1]};
            4'b1001: AluOut = {AluA[30:0], 1'b0};
            4'b1100: AluOut = {AluA[30:0], AluA[31]};
            4'b1101: AluOut = {AluA[0], AluA[31:1]};
            default: AluOut = AluA + AluB;
        endcase
        AluZero = (AluOut == 32'h0);
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] data,
                          input logic [4:0] amt, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_err, input int exp_lat,
                          input bit poke);
        int lat;
        Start   = 1'b1;
        ShiftOp = op;
        Data    = data;
        Amount  = amt;
        @(posedge Clk); #1;
        Start   = 1'b0;
        ShiftOp = 4'b0000;
        Data    = 32'h5A5A_5A5A;
        Amount  = 5'd7;
        lat = 1;
        check({tag, ".ready_busy"}, {31'b0, Ready}, 32'd0);
        check({tag, ".aluop"}, {28'b0, AluOp}, (exp_lat > 1) ? {28'b0, op} : 32'd0);
        while (Done !== 1'b1 && lat < 40) begin
            if (poke && lat == 2) begin
                Start   = 1'b1;
                ShiftOp = 4'b1101;
                Data    = 32'hFFFF_FFFF;
                Amount  = 5'd3;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk); #1;
            lat++;
        end
        Start = 1'b0;
        check({tag, ".done"}, {31'b0, Done}, 32'd1);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, Result, exp_res);
        check({tag, ".rzero"}, {31'b0, ResultZero}, {31'b0, exp_zero});
        check({tag, ".err"}, {31'b0, Err}, {31'b0, exp_err});
        $display("txn %s op=%b data=%h amt=%0d result=%h zero=%b err=%b lat=%0d",
                 tag, op, data, amt, Result, ResultZero, Err, lat);
        @(posedge Clk); #1;
        check({tag, ".done_pulse"}, {31'b0, Done}, 32'd0);
        check({tag, ".ready_after"}, {31'b0, Ready}, 32'd1);
    endtask

    initial begin
        int pulses;
        Reset_n = 1'b0;
        Start   = 1'b0;
        ShiftOp = 4'b0000;
        Data    = 32'h0;
        Amount  = 5'd0;
        #12;
        check("rst.ready", {31'b0, Ready}, 32'd1);
        check("rst.done", {31'b0, Done}, 32'd0);
        check("rst.err", {31'b0, Err}, 32'd0);
        check("rst.result", Result, 32'h0);
        check("rst.rzero", {31'b0, ResultZero}, 32'd1);
        check("rst.aluop", {28'b0, AluOp}, 32'd0);
        check("rst.alua", AluA, 32'h0);
        check("rst.alub", AluB, 32'h0);
        $display("txn reset ready=%b result=%h", Ready, Result);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        run_op("lsl4",   4'b1001, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 1'b0, 5,  1'b0);
        run_op("asr31",  4'b1000, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 1'b0);
        run_op("ror1",   4'b1101, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 1'b0, 2,  1'b0);
        run_op("lsr1",   4'b1010, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b0, 2,  1'b0);
        run_op("rol0",   4'b1100, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 1,  1'b0);
        run_op("illegal",4'b0010, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b0, 1'b1, 1,  1'b0);
        run_op("poke",   4'b1001, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 1'b0, 5,  1'b1);
        run_op("rol4",   4'b1100, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 1'b0, 5,  1'b0);
        run_op("asr3",   4'b1000, 32'h4000_0000, 5'd3,  32'h0800_0000, 1'b0, 1'b0, 4,  1'b0);

        // Abort a long shift with reset at accept+3
        Start   = 1'b1;
        ShiftOp = 4'b1001;
        Data    = 32'h0000_0001;
        Amount  = 5'd10;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check("abort.ready", {31'b0, Ready}, 32'd1);
        check("abort.result", Result, 32'h0);
        check("abort.rzero", {31'b0, ResultZero}, 32'd1);
        check("abort.done", {31'b0, Done}, 32'd0);
        check("abort.aluop", {28'b0, AluOp}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) pulses++;
        end
        check("abort.no_done", pulses, 0);
        $display("txn abort ready=%b result=%h done_pulses=%0d", Ready, Result, pulses);

        run_op("post_rst", 4'b1010, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0, 1'b0, 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
